arty_z7_led_driver: RTL and testbench

Output-side companion to the board's debounced button inputs. It drives NR_OF_LEDS_P user LEDs on the Arty Z7 from a valid/ready command interface. Each LED has a mode (off, on, PWM dim, blink), a duty value, and a glitch-free update rule. The block sits between the control logic or register bank and the LED pins.

---
 rtl/arty_z7_led_pkg.sv | 29 ++
 rtl/arty_z7_led_driver_pwm_channel.sv | 61 ++++++
 rtl/arty_z7_led_driver.sv | 123 ++++++++++++
 tb/tb_arty_z7_led_driver.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arty_z7_led_pkg.sv
// Shared types and helpers for the Arty Z7 LED driver.
// The gamma map is used only when LED_DRIVER_GAMMA_EN is defined.
package arty_z7_led_pkg;

  typedef enum logic [1:0] {
    LED_OFF_E   = 2'd0,
    LED_ON_E    = 2'd1,
    LED_PWM_E   = 2'd2,
    LED_BLINK_E = 2'd3
  } led_mode_t;

  typedef enum logic {
    CMT_IDLE_E    = 1'b0,
    CMT_PENDING_E = 1'b1
  } commit_state_t;

  // Square-law dimming curve; full scale maps to itself so full-on stays gap-free.
  function automatic logic [31:0] gamma_map(input logic [31:0] duty, input int unsigned width);
    logic [63:0] sq;
    logic [31:0] full;
    full = (32'd1 << width) - 32'd1;
    sq   = {32'd0, duty} * {32'd0, duty};
    if (duty == full) begin
      return duty;
    end
    return 32'(sq >> width);
  endfunction

endpackage

// File: rtl/arty_z7_led_driver_pwm_channel.sv
// One LED channel: active mode/duty registers loaded by a commit strobe,
// the raw-output compare and the registered pin drive. Honours LED_DRIVER_GAMMA_EN.
module led_pwm_channel
  import arty_z7_led_pkg::*;
#(
  parameter int PWM_WIDTH_P = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit,
  input  logic [1:0]             commit_mode,
  input  logic [PWM_WIDTH_P-1:0] commit_duty,
  input  logic [PWM_WIDTH_P-1:0] pwm_cnt,
  input  logic                   blink_phase,
  output logic                   led
);

  led_mode_t              mode_reg;
  logic [PWM_WIDTH_P-1:0] eff_duty_reg;
  logic [PWM_WIDTH_P-1:0] eff_duty_next;
  logic                   led_reg;
  logic                   led_next;
  logic                   below_duty;

`ifdef LED_DRIVER_GAMMA_EN
  always_comb eff_duty_next = PWM_WIDTH_P'(gamma_map(32'(commit_duty), PWM_WIDTH_P));
`else
  always_comb eff_duty_next = commit_duty;
`endif

  // The counter never reaches full scale, so a full-scale duty is on every cycle.
  assign below_duty = (pwm_cnt < eff_duty_reg);

  always_comb begin
    led_next = 1'b0;
    case (mode_reg)
      LED_OFF_E:   led_next = 1'b0;
      LED_ON_E:    led_next = 1'b1;
      LED_PWM_E:   led_next = below_duty;
      LED_BLINK_E: led_next = blink_phase & below_duty;
      default:     led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg     <= LED_OFF_E;
      eff_duty_reg <= '0;
      led_reg      <= 1'b0;
    end else begin
      if (commit) begin
        mode_reg     <= led_mode_t'(commit_mode);
        eff_duty_reg <= eff_duty_next;
      end
      led_reg <= led_next;
    end
  end

  assign led = led_reg;

endmodule

// File: rtl/arty_z7_led_driver.sv
// LED driver top: shared PWM counter and blink prescaler, command handshake,
// single pending slot and the boundary-aligned commit FSM. Optional LED_DRIVER_GAMMA_EN.
module arty_z7_led_driver
  import arty_z7_led_pkg::*;
#(
  parameter int NR_OF_LEDS_P  = 4,
  parameter int PWM_WIDTH_P   = 8,
  parameter int BLINK_DIV_P   = 62500000,
  localparam int LED_IDX_W    = (NR_OF_LEDS_P > 1) ? $clog2(NR_OF_LEDS_P) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LED_IDX_W-1:0]    cmd_led,
  input  logic [1:0]              cmd_mode,
  input  logic [PWM_WIDTH_P-1:0]  cmd_duty,
  output logic [NR_OF_LEDS_P-1:0] led
);

  localparam int PERIOD  = (1 << PWM_WIDTH_P) - 1;
  localparam int PRESC_W = $clog2(BLINK_DIV_P);
  localparam logic [PWM_WIDTH_P-1:0] PWM_LAST   = PWM_WIDTH_P'(PERIOD - 1);
  localparam logic [PRESC_W-1:0]     PRESC_LAST = PRESC_W'(BLINK_DIV_P - 1);

  logic [PWM_WIDTH_P-1:0] pwm_cnt_reg;
  logic [PRESC_W-1:0]     presc_reg;
  logic                   blink_phase_reg;
  logic                   pwm_last;
  logic                   presc_last;

  commit_state_t          state_reg;
  commit_state_t          state_next;
  logic                   commit_en;
  logic                   transfer;
  logic                   idx_ok;

  logic [LED_IDX_W-1:0]   pend_led_reg;
  logic [1:0]             pend_mode_reg;
  logic [PWM_WIDTH_P-1:0] pend_duty_reg;

  assign pwm_last   = (pwm_cnt_reg == PWM_LAST);
  assign presc_last = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_reg     <= '0;
      presc_reg       <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      pwm_cnt_reg <= pwm_last ? '0 : pwm_cnt_reg + 1'b1;
      presc_reg   <= presc_last ? '0 : presc_reg + 1'b1;
      if (presc_last) begin
        blink_phase_reg <= ~blink_phase_reg;
      end
    end
  end

  assign cmd_ready = (state_reg == CMT_IDLE_E) & ~rst;
  assign transfer  = cmd_valid & cmd_ready;
  // Out-of-range targets complete the handshake but never occupy the slot.
  assign idx_ok    = (int'(cmd_led) < NR_OF_LEDS_P);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CMT_IDLE_E;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    commit_en  = 1'b0;
    case (state_reg)
      CMT_IDLE_E: begin
        if (transfer && idx_ok) begin
          state_next = CMT_PENDING_E;
        end
      end
      CMT_PENDING_E: begin
        if (pwm_last) begin
          commit_en  = 1'b1;
          state_next = CMT_IDLE_E;
        end
      end
      default: state_next = CMT_IDLE_E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_led_reg  <= '0;
      pend_mode_reg <= '0;
      pend_duty_reg <= '0;
    end else if (transfer && idx_ok) begin
      pend_led_reg  <= cmd_led;
      pend_mode_reg <= cmd_mode;
      pend_duty_reg <= cmd_duty;
    end
  end

  generate
    for (genvar gi = 0; gi < NR_OF_LEDS_P; gi++) begin : g_channel
      logic commit_hit;
      assign commit_hit = commit_en && (pend_led_reg == LED_IDX_W'(gi));

      led_pwm_channel #(
        .PWM_WIDTH_P (PWM_WIDTH_P)
      ) u_channel (
        .clk         (clk),
        .rst         (rst),
        .commit      (commit_hit),
        .commit_mode (pend_mode_reg),
        .commit_duty (pend_duty_reg),
        .pwm_cnt     (pwm_cnt_reg),
        .blink_phase (blink_phase_reg),
        .led         (led[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_arty_z7_led_driver.sv
// Self-checking bench for arty_z7_led_driver against a cycle-indexed behavioural model.
module tb_arty_z7_led_driver;

  localparam int NR  = 4;
  localparam int W   = 4;
  localparam int BD  = 40;
  localparam int PER = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_led = '0;
  logic [1:0]    cmd_mode = '0;
  logic [W-1:0]  cmd_duty = '0;
  logic          cmd_ready;
  logic [NR-1:0] led;

  logic          c5_valid = 1'b0;
  logic [2:0]    c5_led = '0;
  logic [1:0]    c5_mode = '0;
  logic [W-1:0]  c5_duty = '0;
  logic          c5_ready;
  logic [4:0]    c5_leds;

  arty_z7_led_driver #(.NR_OF_LEDS_P(NR), .PWM_WIDTH_P(W), .BLINK_DIV_P(BD)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_led(cmd_led), .cmd_mode(cmd_mode), .cmd_duty(cmd_duty), .led(led)
  );

  arty_z7_led_driver #(.NR_OF_LEDS_P(5), .PWM_WIDTH_P(W), .BLINK_DIV_P(BD)) u_dut5 (
    .clk(clk), .rst(rst), .cmd_valid(c5_valid), .cmd_ready(c5_ready),
    .cmd_led(c5_led), .cmd_mode(c5_mode), .cmd_duty(c5_duty), .led(c5_leds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: cycle n counts from the first cycle after reset release.
  int            m_n;
  int            m_mode [NR];
  int            m_duty [NR];
  bit            m_pend;
  int            m_pl, m_pm, m_pd, m_commit;
  logic [NR-1:0] m_led;

  logic [NR-1:0] obs_led, exp_led;
  logic          obs_ready, exp_ready;
  logic [4:0]    obs5_led;
  logic          obs5_ready;

  function automatic int eff(input int d);
`ifdef LED_DRIVER_GAMMA_EN
    return (d == 15) ? 15 : (d * d) >> W;
`else
    return d;
`endif
  endfunction

  function automatic logic model_raw(input int i);
    int pwm;
    int ph;
    pwm = m_n % PER;
    ph  = (m_n / BD) % 2;
    case (m_mode[i])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return pwm < eff(m_duty[i]);
      default: return (ph == 1) && (pwm < eff(m_duty[i]));
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_pend = 1'b0;
    m_led = '0;
    for (int i = 0; i < NR; i++) begin
      m_mode[i] = 0;
      m_duty[i] = 0;
    end
  endtask

  task automatic model_update(input logic v, input int l, input int m, input int d, input logic r);
    logic [NR-1:0] nl;
    bit            accepted;
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NR; i++) nl[i] = model_raw(i);
    accepted = v && !m_pend;
    if (m_pend && m_n == m_commit) begin
      m_mode[m_pl] = m_pm;
      m_duty[m_pl] = m_pd;
      m_pend = 1'b0;
    end
    if (accepted && l < NR) begin
      m_pend = 1'b1;
      m_pl = l; m_pm = m; m_pd = d;
      // Commit lands on the first period end strictly after the transfer cycle.
      m_commit = m_n + (((m_n % PER) == PER - 1) ? PER : (PER - 1 - (m_n % PER)));
    end
    m_led = nl;
    m_n++;
  endtask

  task automatic tick(input logic v, input logic [1:0] l, input logic [1:0] m,
                      input logic [W-1:0] d, input logic r);
    rst = r; cmd_valid = v; cmd_led = l; cmd_mode = m; cmd_duty = d;
    @(negedge clk);
    obs_led = led; obs_ready = cmd_ready;
    obs5_led = c5_leds; obs5_ready = c5_ready;
    exp_led = m_led;
    exp_ready = !r && !m_pend;
    @(posedge clk);
    model_update(v, int'(l), int'(m), int'(d), r);
    #1;
  endtask

  task automatic send(input logic [1:0] l, input logic [1:0] m, input logic [W-1:0] d);
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick(1'b1, l, m, d, 1'b0);
      if (obs_ready) done = 1'b1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: cmd_ready=%b expected 1 within 40 cycles (led %0d)", obs_ready, l);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b1);
      checks++;
      if (obs_led !== 4'b0000 || obs_ready !== 1'b0 || obs5_led !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold: led=%b ready=%b led5=%b expected 0000 0 00000", obs_led, obs_ready, obs5_led);
      end
    end
    tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    checks++;
    if (obs_led !== 4'b0000 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: led=%b ready=%b expected 0000 1", obs_led, obs_ready);
    end
  endtask

  task automatic test_pwm();
    int cnt = 0;
    send(2'd1, 2'd2, 4'd5);
    for (int k = 0; k < 75; k++) begin
      tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
      checks++;
      if (obs_led !== exp_led || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL pwm_cycle: led=%b ready=%b expected %b %b (n=%0d)", obs_led, obs_ready, exp_led, exp_ready, m_n - 1);
      end
      if (k >= 30 && obs_led[1]) cnt++;
    end
    checks++;
    if (cnt != 3 * eff(5)) begin
      errors++;
      $display("FAIL pwm_duty5_count: high=%0d expected %0d over 45 cycles", cnt, 3 * eff(5));
    end
  endtask

  task automatic test_duty_edges();
    int cnt;
    for (int pass = 0; pass < 2; pass++) begin
      cnt = 0;
      send(2'd0, 2'd2, (pass == 0) ? 4'd0 : 4'd15);
      for (int k = 0; k < 75; k++) begin
        tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
        checks++;
        if (obs_led !== exp_led || obs_ready !== exp_ready) begin
          errors++;
          $display("FAIL duty_edge_cycle: led=%b ready=%b expected %b %b (n=%0d)", obs_led, obs_ready, exp_led, exp_ready, m_n - 1);
        end
        if (k >= 30 && obs_led[0]) cnt++;
      end
      checks++;
      if (cnt != ((pass == 0) ? 0 : 45)) begin
        errors++;
        $display("FAIL duty_edge_count: high=%0d expected %0d (pass %0d)", cnt, (pass == 0) ? 0 : 45, pass);
      end
    end
  endtask

  task automatic test_blink();
    int cnt = 0;
    send(2'd2, 2'd3, 4'd15);
    for (int k = 0; k < 190; k++) begin
      tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
      checks++;
      if (obs_led !== exp_led || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL blink_cycle: led=%b ready=%b expected %b %b (n=%0d)", obs_led, obs_ready, exp_led, exp_ready, m_n - 1);
      end
      if (k >= 30 && k < 110 && obs_led[2]) cnt++;
    end
    checks++;
    if (cnt != BD) begin
      errors++;
      $display("FAIL blink_count: high=%0d expected %0d over %0d cycles", cnt, BD, 2 * BD);
    end
  endtask

  task automatic test_boundary_transfer();
    bit found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (!m_pend && (m_n % PER) == PER - 1) found = 1'b1;
      else tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL boundary_search: found=%b expected 1", found);
    end else begin
      tick(1'b1, 2'd0, 2'd0, 4'd0, 1'b0);
      cmd_valid = 1'b0;
      checks++;
      if (obs_ready !== 1'b1) begin
        errors++;
        $display("FAIL boundary_accept: ready=%b expected 1", obs_ready);
      end
      for (int k = 0; k < 20; k++) begin
        tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
        checks++;
        if (obs_led !== exp_led || obs_ready !== exp_ready) begin
          errors++;
          $display("FAIL boundary_cycle: led=%b ready=%b expected %b %b (n=%0d)", obs_led, obs_ready, exp_led, exp_ready, m_n - 1);
        end
      end
    end
  endtask

  task automatic test_invalid_index();
    c5_valid = 1'b1; c5_led = 3'd4; c5_mode = 2'd1; c5_duty = 4'd0;
    tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    c5_valid = 1'b0;
    checks++;
    if (obs5_ready !== 1'b1) begin
      errors++;
      $display("FAIL inv_first_accept: ready5=%b expected 1", obs5_ready);
    end
    tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    checks++;
    if (obs5_ready !== 1'b0) begin
      errors++;
      $display("FAIL inv_pending_ready: ready5=%b expected 0", obs5_ready);
    end
    for (int k = 0; k < 20; k++) tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    checks++;
    if (obs5_led !== 5'b10000 || obs5_ready !== 1'b1) begin
      errors++;
      $display("FAIL inv_led4_on: led5=%b ready5=%b expected 10000 1", obs5_led, obs5_ready);
    end
    c5_valid = 1'b1; c5_led = 3'd7; c5_mode = 2'd2; c5_duty = 4'd3;
    tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    c5_valid = 1'b0;
    checks++;
    if (obs5_ready !== 1'b1) begin
      errors++;
      $display("FAIL inv_idx7_accept: ready5=%b expected 1", obs5_ready);
    end
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
      checks++;
      if (obs5_led !== 5'b10000 || obs5_ready !== 1'b1) begin
        errors++;
        $display("FAIL inv_idx7_ignored: led5=%b ready5=%b expected 10000 1", obs5_led, obs5_ready);
      end
    end
  endtask

  task automatic test_reset_pending();
    int cnt = 0;
    send(2'd3, 2'd1, 4'd0);
    tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b1);
    tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b1);
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstpend_ready: ready=%b expected 0", obs_ready);
    end
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
      checks++;
      if (obs_led !== exp_led || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL rstpend_cycle: led=%b ready=%b expected %b %b (n=%0d)", obs_led, obs_ready, exp_led, exp_ready, m_n - 1);
      end
      if (obs_led[3]) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL rstpend_dropped: led3 high=%0d expected 0", cnt);
    end
  endtask

  task automatic test_duty8();
    int cnt = 0;
    send(2'd1, 2'd2, 4'd8);
    for (int k = 0; k < 75; k++) begin
      tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
      checks++;
      if (obs_led !== exp_led || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL duty8_cycle: led=%b ready=%b expected %b %b (n=%0d)", obs_led, obs_ready, exp_led, exp_ready, m_n - 1);
      end
      if (k >= 30 && obs_led[1]) cnt++;
    end
    checks++;
    if (cnt != 3 * eff(8)) begin
      errors++;
      $display("FAIL duty8_count: high=%0d expected %0d over 45 cycles", cnt, 3 * eff(8));
    end
  endtask

  task automatic test_random();
    logic [1:0]   rl, rm;
    logic [W-1:0] rd;
    int           gap;
    for (int c = 0; c < 10; c++) begin
      gap = int'($urandom_range(0, 20));
      for (int k = 0; k < gap; k++) begin
        tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
        checks++;
        if (obs_led !== exp_led || obs_ready !== exp_ready) begin
          errors++;
          $display("FAIL random_cycle: led=%b ready=%b expected %b %b (n=%0d)", obs_led, obs_ready, exp_led, exp_ready, m_n - 1);
        end
      end
      rl = 2'($urandom_range(0, 3));
      rm = 2'($urandom_range(0, 3));
      rd = 4'($urandom_range(0, 15));
      $display("random cmd %0d: led=%0d mode=%0d duty=%0d", c, rl, rm, rd);
      send(rl, rm, rd);
    end
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
      checks++;
      if (obs_led !== exp_led || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL random_tail: led=%b ready=%b expected %b %b (n=%0d)", obs_led, obs_ready, exp_led, exp_ready, m_n - 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_pwm();
    test_duty_edges();
    test_blink();
    test_boundary_transfer();
    test_invalid_index();
    test_reset_pending();
    test_duty8();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
